// File: rtl/serial_subtractor_if.sv
// Operand/result bus for the bit-serial subtractor.
// Handshake: start is taken only on an edge where ready=1; A, B and Bin are sampled on that edge alone.
// done is a one-cycle pulse during which D/Bout/overflow are valid. ready and done are never high together.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] D;
  logic             Bout;
  logic             overflow;

  modport master (
    output start, A, B, Bin,
    input  ready, done, D, Bout, overflow
  );

  modport slave (
    input  start, A, B, Bin,
    output ready, done, D, Bout, overflow
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial D = A - B - Bin, LSB first, one full-subtractor cell and a borrow flop.
// Results are published to D/Bout/overflow only when the last bit is produced.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                clock,
  input  logic                reset,
  serial_subtractor_if.slave  bus,
  output logic [1:0]          dbg_state
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             br;
  logic [WIDTH-1:0] d_q;
  logic             bout_q;
  logic             ovf_q;

  logic a_bit;
  logic b_bit;
  logic d_bit;
  logic br_next;

  always_comb begin
    a_bit   = a_sr[0];
    b_bit   = b_sr[0];
    d_bit   = a_bit ^ b_bit ^ br;
    br_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      br     <= 1'b0;
      d_q    <= '0;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sr   <= bus.A;
            b_sr   <= bus.B;
            br     <= bus.Bin;
            res_sr <= '0;
            cnt    <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
          res_sr <= {d_bit, res_sr[WIDTH-1:1]};
          br     <= br_next;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            // On the last bit the operand LSBs are the latched MSBs, so they drive the overflow rule.
            d_q    <= {d_bit, res_sr[WIDTH-1:1]};
            bout_q <= br_next;
            ovf_q  <= (a_bit ^ b_bit) & (d_bit ^ a_bit);
            state  <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ready    = (state == IDLE);
  assign bus.done     = (state == DONE);
  assign bus.D        = d_q;
  assign bus.Bout     = bout_q;
  assign bus.overflow = ovf_q;
  assign dbg_state    = state;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: WIDTH=8 vectors and corner sequences, WIDTH=2 exhaustive sweep.
module tb_serial_subtractor;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  serial_subtractor_if #(.WIDTH(8)) bus8();
  serial_subtractor_if #(.WIDTH(2)) bus2();
  logic [1:0] dbg8;
  logic [1:0] dbg2;

  serial_subtractor #(.WIDTH(8)) dut8 (.clock(clock), .reset(reset), .bus(bus8), .dbg_state(dbg8));
  serial_subtractor #(.WIDTH(2)) dut2 (.clock(clock), .reset(reset), .bus(bus2), .dbg_state(dbg2));

  int checks = 0;
  int errors = 0;
  int done8_cnt = 0;
  logic [9:0] exp8_q[$];
  logic [3:0] exp2_q[$];
  logic [9:0] e8;
  logic [3:0] e2;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] d;
    logic       bout;
    logic       ovf;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Packed as {Bout, overflow, D}
  function automatic logic [3:0] model2(input logic [1:0] a, input logic [1:0] b, input logic bin);
    logic [2:0] diff;
    logic       ovf;
    diff = {1'b0, a} - {1'b0, b} - {2'b00, bin};
    ovf  = (a[1] != b[1]) && (diff[1] != a[1]);
    return {diff[2], ovf, diff[1:0]};
  endfunction

  always @(negedge clock) begin
    if (bus8.done === 1'b1) begin
      done8_cnt++;
      check("ready_done_excl8", {31'd0, bus8.ready}, 32'd0);
      if (exp8_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done8: got done with D=%0h, required no done", bus8.D);
      end else begin
        e8 = exp8_q.pop_front();
        check("result8", {22'd0, bus8.Bout, bus8.overflow, bus8.D}, {22'd0, e8});
      end
    end
  end

  always @(negedge clock) begin
    if (bus2.done === 1'b1) begin
      if (exp2_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done2: got done with D=%0h, required no done", bus2.D);
      end else begin
        e2 = exp2_q.pop_front();
        check("result2", {28'd0, bus2.Bout, bus2.overflow, bus2.D}, {28'd0, e2});
      end
    end
  end

  task automatic wait_ready8();
    int n = 0;
    while (bus8.ready !== 1'b1 && n < 40) begin
      @(negedge clock);
      n++;
    end
    if (n >= 40) check("ready_wait8", {31'd0, bus8.ready}, 32'd1);
  endtask

  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                        input logic [9:0] exp);
    int n;
    wait_ready8();
    bus8.A = a;
    bus8.B = b;
    bus8.Bin = bin;
    bus8.start = 1'b1;
    exp8_q.push_back(exp);
    @(posedge clock);
    #1;
    bus8.start = 1'b0;
    bus8.A = 8'($urandom_range(0, 255));
    bus8.B = 8'($urandom_range(0, 255));
    bus8.Bin = 1'($urandom_range(0, 1));
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (bus8.done !== 1'b1 && n < 20);
    check("latency8", n, 9);
    @(negedge clock);
    check("ready_after_done8", {31'd0, bus8.ready}, 32'd1);
  endtask

  task automatic issue2(input logic [1:0] a, input logic [1:0] b, input logic bin);
    int n = 0;
    while (bus2.ready !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (n >= 20) check("ready_wait2", {31'd0, bus2.ready}, 32'd1);
    bus2.A = a;
    bus2.B = b;
    bus2.Bin = bin;
    bus2.start = 1'b1;
    exp2_q.push_back(model2(a, b, bin));
    @(posedge clock);
    #1;
    bus2.start = 1'b0;
    bus2.A = 2'($urandom_range(0, 3));
    bus2.B = 2'($urandom_range(0, 3));
  endtask

  initial begin
    int dstart;
    int n;
    vecs[0] = '{a: 8'h05, b: 8'h03, bin: 1'b0, d: 8'h02, bout: 1'b0, ovf: 1'b0};
    vecs[1] = '{a: 8'h03, b: 8'h05, bin: 1'b0, d: 8'hFE, bout: 1'b1, ovf: 1'b0};
    vecs[2] = '{a: 8'h00, b: 8'h00, bin: 1'b1, d: 8'hFF, bout: 1'b1, ovf: 1'b0};
    vecs[3] = '{a: 8'h80, b: 8'h01, bin: 1'b0, d: 8'h7F, bout: 1'b0, ovf: 1'b1};
    vecs[4] = '{a: 8'h7F, b: 8'hFF, bin: 1'b0, d: 8'h80, bout: 1'b1, ovf: 1'b1};

    reset = 1'b1;
    bus8.start = 1'b0; bus8.A = '0; bus8.B = '0; bus8.Bin = 1'b0;
    bus2.start = 1'b0; bus2.A = '0; bus2.B = '0; bus2.Bin = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_ready", {31'd0, bus8.ready}, 32'd1);
    check("rst_done", {31'd0, bus8.done}, 32'd0);
    check("rst_D", {24'd0, bus8.D}, 32'd0);
    check("rst_Bout", {31'd0, bus8.Bout}, 32'd0);
    check("rst_overflow", {31'd0, bus8.overflow}, 32'd0);
    check("rst_state", {30'd0, dbg8}, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 5; i++)
      issue8(vecs[i].a, vecs[i].b, vecs[i].bin, {vecs[i].bout, vecs[i].ovf, vecs[i].d});

    // Second start mid-operation with churning operands must be ignored.
    dstart = done8_cnt;
    wait_ready8();
    bus8.A = 8'h10; bus8.B = 8'h01; bus8.Bin = 1'b0; bus8.start = 1'b1;
    exp8_q.push_back({1'b0, 1'b0, 8'h0F});
    @(posedge clock);
    #1;
    bus8.start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      bus8.A = 8'($urandom_range(0, 255));
      bus8.B = 8'($urandom_range(0, 255));
      bus8.Bin = 1'($urandom_range(0, 1));
      bus8.start = (k == 3);
      if (k == 3) begin
        bus8.A = 8'hFF;
        bus8.B = 8'hFF;
      end
    end
    n = 8;
    while (bus8.done !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("latency_ignore", n, 9);
    repeat (14) @(negedge clock);
    check("single_done", done8_cnt - dstart, 1);

    // Reset sampled at E4 aborts the operation.
    dstart = done8_cnt;
    wait_ready8();
    bus8.A = 8'h40; bus8.B = 8'h11; bus8.Bin = 1'b0; bus8.start = 1'b1;
    @(posedge clock);
    #1;
    bus8.start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      reset = (k == 4);
    end
    @(negedge clock);
    reset = 1'b0;
    check("abort_ready", {31'd0, bus8.ready}, 32'd1);
    check("abort_D", {24'd0, bus8.D}, 32'd0);
    check("abort_Bout", {31'd0, bus8.Bout}, 32'd0);
    check("abort_overflow", {31'd0, bus8.overflow}, 32'd0);
    check("abort_state", {30'd0, dbg8}, 32'd0);
    repeat (12) @(negedge clock);
    check("abort_no_done", done8_cnt - dstart, 0);
    issue8(8'h05, 8'h03, 1'b0, {1'b0, 1'b0, 8'h02});

    // Reset and start on the same edge: start is dropped.
    dstart = done8_cnt;
    wait_ready8();
    bus8.A = 8'h33; bus8.B = 8'h22; bus8.start = 1'b1; reset = 1'b1;
    @(negedge clock);
    bus8.start = 1'b0; reset = 1'b0;
    check("rst_start_ready", {31'd0, bus8.ready}, 32'd1);
    repeat (12) @(negedge clock);
    check("rst_start_no_done", done8_cnt - dstart, 0);

    for (int i = 0; i < 32; i++) begin
      logic [4:0] v;
      v = 5'(i);
      issue2(v[3:2], v[1:0], v[4]);
    end

    n = 0;
    while ((exp8_q.size() != 0 || exp2_q.size() != 0) && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("queues_drained", exp8_q.size() + exp2_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial N-bit subtractor with borrow-in/borrow-out. It computes D = A − B − Bin one bit per clock, LSB first, using a single full-subtractor cell and a borrow flip-flop. It is the inverse-direction companion to the combinational ripple adders in the lab datapath, trading latency for area. A start/ready/done handshake lets a controller or testbench issue one operation at a time.

## Interface
- WIDTH, 8: operand and result width in bits; must be ≥ 2.

- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request pulse; accepted only while ready = 1.
- A  in  WIDTH  minuend; sampled on the accepting edge only.
- B  in  WIDTH  subtrahend; sampled on the accepting edge only.
- Bin  in  1  borrow-in; sampled on the accepting edge only.
- ready  out  1  high in IDLE; block can accept start.
- done  out  1  one-cycle pulse: result valid.
- D  out  WIDTH  difference A − B − Bin, mod 2^WIDTH.
- Bout  out  1  borrow-out: 1 iff A < B + Bin (unsigned).
- overflow  out  1  signed overflow: A[MSB] ≠ B[MSB] and D[MSB] ≠ A[MSB].

## Operation
- FSM states: IDLE, RUN, DONE. Reset forces IDLE.
- IDLE: ready = 1. On `start` = 1:
  - load A and B into shift registers;
  - load the borrow flop with Bin;
  - clear the bit counter;
  - go to RUN.
- RUN: each cycle consumes the operand LSBs a, b and the borrow br:
  - d = a ^ b ^ br;
  - br_next = (~a & b) | (~(a ^ b) & br);
  - d shifts into the result register MSB; both operand registers shift right by one;
  - the counter increments;
  - after the WIDTH-th bit, go to DONE.
- DONE: done = 1 for this single cycle.
  - D, Bout (final borrow flop) and overflow are valid and registered.
  - overflow uses the latched operand MSBs, not the live A/B inputs.
  - Next edge returns to IDLE.
- start is ignored in RUN and DONE. It is neither queued nor allowed to corrupt the operation in progress.
- A, B and Bin may change freely after the accepting edge.
- Outputs D, Bout and overflow hold their last result until the next operation's DONE. Internal shifting is not visible on D.

## Timing
- Reset values: ready = 1, done = 0, D = 0, Bout = 0, overflow = 0; state = IDLE; counter, borrow flop and shift registers = 0.
- Latency: start sampled at edge E0; RUN occupies edges E1..E(WIDTH); done is high in the cycle following edge E(WIDTH).
- Throughput: one operation per WIDTH+2 cycles.
  - ready rises the cycle after done.
  - A start held high continuously is accepted on the first edge at which ready = 1.
- ready and done are decoded from state only. They are never high in the same cycle.
- Reset during RUN or DONE:
  - abort the operation;
  - return to IDLE;
  - clear all outputs per the reset values above;
  - no done pulse is produced.
- Reset asserted together with start: reset wins; the start is dropped.
- Counter width is clog2(WIDTH)+1 bits. No wrap-around is permitted within one operation.

## Test plan
- WIDTH=8; A=0x05, B=0x03, Bin=0 → done exactly 9 cycles after the start edge; D=0x02, Bout=0, overflow=0; ready high the next cycle.
- A=0x03, B=0x05, Bin=0 → D=0xFE, Bout=1, overflow=0. A=0x00, B=0x00, Bin=1 → D=0xFF, Bout=1, overflow=0.
- A=0x80, B=0x01, Bin=0 → D=0x7F, Bout=0, overflow=1. A=0x7F, B=0xFF, Bin=0 → D=0x80, Bout=1, overflow=1.
- Start at E0 with A=0x10, B=0x01; pulse start again at E3 with A=0xFF, B=0xFF and change A/B every cycle → exactly one done; D=0x0F, Bout=0; the second start is ignored.
- Assert reset for one cycle at E4 of an operation → no done; D=0, Bout=0, overflow=0; ready=1 the cycle after reset. A subsequent 0x05−0x03 completes normally.
- WIDTH=2 exhaustive sweep: all 32 {Bin, A, B} combinations issued back-to-back. Every result must match the expected {Bout, D} = {1'b0, A} − B − Bin, with overflow checked against the signed-overflow rule.
